mul_lane_sequencer: RTL and testbench
=====================================

// Module: mul_lane_sequencer
// PURPOSE
// Per-lane element sequencer that drives the vector multiply unit through the vector_lane_if multiply port.
// Accepts one vector multiply instruction and reads operands per element from the lane register file.
// Issues each active element to the multiply unit, waits for done_mu and returns results to lane writeback.
// Sits between lane decode/issue and multiply_unit; it is the initiator side of the start_mu/done_mu handshake.
// PARAMETERS
// VLMAX    32  max elements per lane per instruction
// EIDX_W   $clog2(VLMAX)  element index width
// TIMEOUT  64  cycles to wait for done_mu before flagging an exception
// PORTS
// CLK            in   1       clock
// nRST           in   1       asynchronous active-low reset
// instr_valid    in   1       instruction offered
// instr_ready    out  1       sequencer idle, accepts instruction
// vl             in   EIDX_W+1  element count, 0..VLMAX
// sew            in   2       sew_t (SEW8/SEW16/SEW32)
// vm             in   1       1 = unmasked, 0 = honour mask bit
// is_signed_mul  in   2       [1]=vs2 signed, [0]=vs1 signed
// high_low, mul_widen_ena, multiply_type, multiply_pos_neg  in  1 each  op controls, latched on accept
// rf_ren         out  1       register-file read request
// rf_eidx        out  EIDX_W  element index read
// rf_vs1, rf_vs2, rf_vs3  in  32 each  operand data, valid 1 cycle after rf_ren
// rf_mask        in   1       v0 mask bit for rf_eidx, same timing as rf_vs*
// start_mu       out  1       one-cycle start pulse to multiply unit
// decode_done    out  1       one-cycle release pulse to multiply unit
// vs1_data, vs2_data, vs3_data  out  32 each  operands to multiply unit
// mu_sew, mu_is_signed, mu_high_low, mu_widen, mu_type, mu_pos_neg  out  -  latched controls to multiply unit
// done_mu        in   1       multiply unit result valid
// wdata_mu       in   32      multiply unit result
// exception_mu   in   1       multiply unit exception, sampled with done_mu
// wb_valid/wb_ready  out/in  1  writeback handshake
// wb_eidx, wb_data   out  EIDX_W/32  writeback element index and data
// instr_done     out  1       one-cycle pulse when instruction completes
// instr_exc      out  1       valid with instr_done; 1 = aborted by exception or timeout
// BEHAVIOUR
// Reset: state IDLE; all outputs 0 except instr_ready=1; eidx, timer and latched controls cleared.
// FSM IDLE -> READ -> ISSUE -> WAIT -> WB -> (READ | DONE) -> IDLE.
// IDLE: instr_ready=1; on instr_valid latch controls/vl, eidx=0; vl==0 -> DONE, else READ.
// READ: rf_ren=1, rf_eidx=eidx for exactly one cycle -> ISSUE.
// ISSUE: capture rf_vs1/2/3 into operand regs, held stable until WAIT exits; if vm==0 && rf_mask==0 the
//   element is skipped: no start_mu, no writeback, go to NEXT; else pulse start_mu, timer=0 -> WAIT.
// WAIT: timer++; on done_mu: capture wdata_mu, pulse decode_done same cycle; exception_mu=1 -> DONE with exc;
//   else -> WB. timer reaching TIMEOUT-1 without done_mu -> pulse decode_done, DONE with exc.
// WB: wb_valid=1, wb_eidx=eidx, wb_data held until wb_ready; on handshake -> NEXT.
// NEXT (folded into the exit of ISSUE-skip/WB): eidx==vl-1 -> DONE, else eidx++ -> READ.
// DONE: instr_done=1 one cycle, instr_exc as recorded -> IDLE (instr_ready rises the following cycle).
// Rules: start_mu and decode_done are never asserted in the same cycle; at least 1 cycle separates
//   decode_done from the next start_mu. done_mu outside WAIT is ignored. eidx never wraps past vl-1.
// Width: vl holds VLMAX, so vl is EIDX_W+1 bits; comparison uses vl-1 only when vl!=0.
// Reset mid-operation: immediate return to IDLE; no pending writeback or instr_done is emitted.
// STRUCTURE
// rv32v_types_pkg: sew_t (existing), new mul_seq_state_t enum {IDLE,READ,ISSUE,WAIT,WB,DONE}.
// Single module; timeout counter inline; no sub-module.
// TESTING
// vl=4, SEW32, vm=1, vs1=3, vs2=5 each elem -> 4 wb beats eidx 0..3 data 15, then instr_done, exc=0.
// vl=4, vm=0, mask=1010 -> wb only for eidx 1,3; no start_mu for eidx 0,2; instr_done once.
// vl=0 -> instr_done the cycle after accept, no rf_ren, no start_mu, no wb_valid.
// wb_ready held low 5 cycles on eidx 1 -> wb_data/wb_eidx stable, no rf_ren for eidx 2 until handshake.
// done_mu never arrives -> decode_done at cycle TIMEOUT after start_mu, instr_done with instr_exc=1.
// Assert nRST while in WAIT on eidx 2 -> outputs at reset values, instr_ready=1, no stray wb_valid.

Source files
------------

// File: rtl/rv32v_types_pkg.sv
// Shared RV32V lane types.
// sew_t           : selected element width encoding used across the lane.
// mul_seq_state_t : state encoding of the per-lane multiply element sequencer.
// MUL_SEQ_*       : default sizing of the multiply sequencer.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10
  } sew_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    ISSUE,
    WAIT,
    WB,
    DONE
  } mul_seq_state_t;

  localparam int MUL_SEQ_VLMAX   = 32;
  localparam int MUL_SEQ_TIMEOUT = 64;

endpackage

// File: rtl/mul_lane_sequencer.sv
// Per-lane element sequencer for the vector multiply unit.
// Accepts one vector multiply instruction, reads each element's operands from
// the lane register file, issues active elements to the multiply unit with a
// start_mu / done_mu handshake and returns results to lane writeback.
// Ports:
//   CLK, nRST                     clock, asynchronous active-low reset
//   instr_valid/instr_ready       instruction handshake (ready only when idle)
//   vl, sew, vm, is_signed_mul,
//   high_low, mul_widen_ena,
//   multiply_type,
//   multiply_pos_neg              instruction controls, latched on accept
//   rf_ren, rf_eidx               register-file read request and element index
//   rf_vs1/2/3, rf_mask           operand data and v0 mask, valid 1 cycle after rf_ren
//   start_mu, decode_done         start and release pulses to the multiply unit
//   vs1/2/3_data, mu_*            operands and latched controls to the multiply unit
//   done_mu, wdata_mu,
//   exception_mu                  multiply unit result and exception
//   wb_valid/wb_ready,
//   wb_eidx, wb_data              element writeback handshake
//   instr_done, instr_exc         completion pulse and abort flag
module mul_lane_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int VLMAX   = MUL_SEQ_VLMAX,
  parameter int EIDX_W  = $clog2(VLMAX),
  parameter int TIMEOUT = MUL_SEQ_TIMEOUT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [EIDX_W:0]   vl,
  input  sew_t              sew,
  input  logic              vm,
  input  logic [1:0]        is_signed_mul,
  input  logic              high_low,
  input  logic              mul_widen_ena,
  input  logic              multiply_type,
  input  logic              multiply_pos_neg,
  output logic              rf_ren,
  output logic [EIDX_W-1:0] rf_eidx,
  input  logic [31:0]       rf_vs1,
  input  logic [31:0]       rf_vs2,
  input  logic [31:0]       rf_vs3,
  input  logic              rf_mask,
  output logic              start_mu,
  output logic              decode_done,
  output logic [31:0]       vs1_data,
  output logic [31:0]       vs2_data,
  output logic [31:0]       vs3_data,
  output sew_t              mu_sew,
  output logic [1:0]        mu_is_signed,
  output logic              mu_high_low,
  output logic              mu_widen,
  output logic              mu_type,
  output logic              mu_pos_neg,
  input  logic              done_mu,
  input  logic [31:0]       wdata_mu,
  input  logic              exception_mu,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [EIDX_W-1:0] wb_eidx,
  output logic [31:0]       wb_data,
  output logic              instr_done,
  output logic              instr_exc
);

  localparam int VL_W  = EIDX_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT);

  mul_seq_state_t    r_state;
  mul_seq_state_t    w_next_state;
  logic [VL_W-1:0]   r_vl;
  logic [EIDX_W-1:0] r_eidx;
  logic [TMR_W-1:0]  r_timer;
  logic              r_vm;
  sew_t              r_sew;
  logic [1:0]        r_is_signed;
  logic              r_high_low;
  logic              r_widen;
  logic              r_type;
  logic              r_pos_neg;
  logic [31:0]       r_vs1;
  logic [31:0]       r_vs2;
  logic [31:0]       r_vs3;
  logic [31:0]       r_wb_data;
  logic              r_exc;

  logic              w_last;
  logic              w_skip;
  logic              w_timeout;

  // The vl-1 compare is guarded so an empty instruction never looks like a
  // last element through the wrap of vl-1.
  assign w_last    = (r_vl != '0) && ({1'b0, r_eidx} == (r_vl - VL_W'(1)));
  assign w_skip    = !r_vm && !rf_mask;
  assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));

  // During ISSUE the operands come straight from the register file so they
  // are valid alongside start_mu; afterwards the captured copy holds them.
  assign vs1_data = (r_state == ISSUE) ? rf_vs1 : r_vs1;
  assign vs2_data = (r_state == ISSUE) ? rf_vs2 : r_vs2;
  assign vs3_data = (r_state == ISSUE) ? rf_vs3 : r_vs3;

  assign rf_eidx      = r_eidx;
  assign wb_eidx      = r_eidx;
  assign wb_data      = r_wb_data;
  assign mu_sew       = r_sew;
  assign mu_is_signed = r_is_signed;
  assign mu_high_low  = r_high_low;
  assign mu_widen     = r_widen;
  assign mu_type      = r_type;
  assign mu_pos_neg   = r_pos_neg;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs. The exit of a skipped ISSUE and of a
  // completed WB share the "next element" decision: finish on the last
  // element, otherwise read the following one.
  always_comb begin
    w_next_state = r_state;
    instr_ready  = 1'b0;
    rf_ren       = 1'b0;
    start_mu     = 1'b0;
    decode_done  = 1'b0;
    wb_valid     = 1'b0;
    instr_done   = 1'b0;
    instr_exc    = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_next_state = (vl == '0) ? DONE : READ;
        end
      end
      READ: begin
        rf_ren       = 1'b1;
        w_next_state = ISSUE;
      end
      ISSUE: begin
        if (w_skip) begin
          w_next_state = w_last ? DONE : READ;
        end else begin
          start_mu     = 1'b1;
          w_next_state = WAIT;
        end
      end
      WAIT: begin
        if (done_mu) begin
          decode_done  = 1'b1;
          w_next_state = exception_mu ? DONE : WB;
        end else if (w_timeout) begin
          decode_done  = 1'b1;
          w_next_state = DONE;
        end
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) begin
          w_next_state = w_last ? DONE : READ;
        end
      end
      DONE: begin
        instr_done   = 1'b1;
        instr_exc    = r_exc;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: latched controls, element index, operand capture, result
  // capture and the done_mu watchdog. The element index only advances when
  // another element follows, so it never passes vl-1.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_vl        <= '0;
      r_eidx      <= '0;
      r_timer     <= '0;
      r_vm        <= 1'b0;
      r_sew       <= SEW8;
      r_is_signed <= '0;
      r_high_low  <= 1'b0;
      r_widen     <= 1'b0;
      r_type      <= 1'b0;
      r_pos_neg   <= 1'b0;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_vs3       <= '0;
      r_wb_data   <= '0;
      r_exc       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_vl        <= vl;
            r_eidx      <= '0;
            r_vm        <= vm;
            r_sew       <= sew;
            r_is_signed <= is_signed_mul;
            r_high_low  <= high_low;
            r_widen     <= mul_widen_ena;
            r_type      <= multiply_type;
            r_pos_neg   <= multiply_pos_neg;
            r_exc       <= 1'b0;
          end
        end
        ISSUE: begin
          r_vs1   <= rf_vs1;
          r_vs2   <= rf_vs2;
          r_vs3   <= rf_vs3;
          r_timer <= '0;
          if (w_skip && !w_last) begin
            r_eidx <= r_eidx + EIDX_W'(1);
          end
        end
        WAIT: begin
          r_timer <= r_timer + TMR_W'(1);
          if (done_mu) begin
            r_wb_data <= wdata_mu;
            if (exception_mu) begin
              r_exc <= 1'b1;
            end
          end else if (w_timeout) begin
            r_exc <= 1'b1;
          end
        end
        WB: begin
          if (wb_ready && !w_last) begin
            r_eidx <= r_eidx + EIDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_lane_sequencer.sv
// Directed self-checking bench for mul_lane_sequencer (default parameters:
// VLMAX=32, TIMEOUT=64). A small register-file stub returns fixed operands
// and a mask vector; a multiply-unit stub answers start_mu with the product
// of the issued operands after a fixed latency.
module tb_mul_lane_sequencer;
  import rv32v_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  vl;
  sew_t        sew;
  logic        vm;
  logic [1:0]  is_signed_mul;
  logic        high_low;
  logic        mul_widen_ena;
  logic        multiply_type;
  logic        multiply_pos_neg;
  logic        rf_ren;
  logic [4:0]  rf_eidx;
  logic [31:0] rf_vs1;
  logic [31:0] rf_vs2;
  logic [31:0] rf_vs3;
  logic        rf_mask;
  logic        start_mu;
  logic        decode_done;
  logic [31:0] vs1_data;
  logic [31:0] vs2_data;
  logic [31:0] vs3_data;
  sew_t        mu_sew;
  logic [1:0]  mu_is_signed;
  logic        mu_high_low;
  logic        mu_widen;
  logic        mu_type;
  logic        mu_pos_neg;
  logic        done_mu;
  logic [31:0] wdata_mu;
  logic        exception_mu;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_eidx;
  logic [31:0] wb_data;
  logic        instr_done;
  logic        instr_exc;

  int          checks;
  int          failures;
  int          cyc;
  int          validCyc;
  int          nStart;
  int          nRen;
  int          nWb;
  int          nWbValid;
  int          nDec;
  int          nDone;
  int          doneCyc;
  int          startCyc;
  int          decCyc;
  int          lastDec;
  int          gapViol;
  int          bothHigh;
  logic        lastExc;
  int          wbEidx [0:63];
  logic [31:0] wbData [0:63];
  int          startEidx [0:63];
  logic [31:0] maskVec;
  logic        muEnable;
  int          muSkipEidx;
  int          muLatency;
  logic [31:0] opA;
  logic [31:0] opB;
  int          n;

  mul_lane_sequencer dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .vl               (vl),
    .sew              (sew),
    .vm               (vm),
    .is_signed_mul    (is_signed_mul),
    .high_low         (high_low),
    .mul_widen_ena    (mul_widen_ena),
    .multiply_type    (multiply_type),
    .multiply_pos_neg (multiply_pos_neg),
    .rf_ren           (rf_ren),
    .rf_eidx          (rf_eidx),
    .rf_vs1           (rf_vs1),
    .rf_vs2           (rf_vs2),
    .rf_vs3           (rf_vs3),
    .rf_mask          (rf_mask),
    .start_mu         (start_mu),
    .decode_done      (decode_done),
    .vs1_data         (vs1_data),
    .vs2_data         (vs2_data),
    .vs3_data         (vs3_data),
    .mu_sew           (mu_sew),
    .mu_is_signed     (mu_is_signed),
    .mu_high_low      (mu_high_low),
    .mu_widen         (mu_widen),
    .mu_type          (mu_type),
    .mu_pos_neg       (mu_pos_neg),
    .done_mu          (done_mu),
    .wdata_mu         (wdata_mu),
    .exception_mu     (exception_mu),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_eidx          (wb_eidx),
    .wb_data          (wb_data),
    .instr_done       (instr_done),
    .instr_exc        (instr_exc)
  );

  // Free-running clock and cycle counter.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Register-file mask bit for the element being read.
  assign rf_mask = maskVec[rf_eidx];

  // Observation of DUT handshakes, sampled mid-cycle.
  always @(negedge CLK) begin
    if (rf_ren === 1'b1) nRen++;
    if (start_mu === 1'b1) begin
      if (nStart == 0) startCyc = cyc;
      if (nStart < 64) startEidx[nStart] = int'(rf_eidx);
      if (cyc - lastDec < 2) gapViol++;
      nStart++;
    end
    if (decode_done === 1'b1) begin
      decCyc  = cyc;
      lastDec = cyc;
      nDec++;
    end
    if (start_mu === 1'b1 && decode_done === 1'b1) bothHigh++;
    if (wb_valid === 1'b1) nWbValid++;
    if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (nWb < 64) begin
        wbEidx[nWb] = int'(wb_eidx);
        wbData[nWb] = wb_data;
      end
      nWb++;
    end
    if (instr_done === 1'b1) begin
      doneCyc = cyc;
      lastExc = instr_exc;
      nDone++;
    end
  end

  // Multiply-unit stub: answers each start_mu after muLatency cycles unless
  // disabled globally or for one chosen element.
  initial begin
    done_mu      = 1'b0;
    wdata_mu     = 32'h0;
    exception_mu = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (start_mu === 1'b1 && muEnable && int'(rf_eidx) != muSkipEidx) begin
        opA = vs1_data;
        opB = vs2_data;
        repeat (muLatency) @(posedge CLK);
        #1;
        done_mu  = 1'b1;
        wdata_mu = opA * opB;
        @(posedge CLK);
        #1;
        done_mu  = 1'b0;
        wdata_mu = 32'h0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounters();
    nStart   = 0;
    nRen     = 0;
    nWb      = 0;
    nWbValid = 0;
    nDec     = 0;
    nDone    = 0;
    gapViol  = 0;
    bothHigh = 0;
    lastExc  = 1'bx;
    lastDec  = -100;
  endtask

  task automatic applyStimulus(input logic [5:0] vlIn, input logic vmIn, input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK);
    #1;
    rf_vs1      = a;
    rf_vs2      = b;
    rf_vs3      = 32'h0;
    vl          = vlIn;
    vm          = vmIn;
    validCyc    = cyc;
    instr_valid = 1'b1;
    @(posedge CLK);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    int k = 0;
    while (nDone == 0 && k < maxCycles) begin
      @(posedge CLK);
      k++;
    end
    @(negedge CLK);
    checkOutput(tag, 32'(nDone), 32'd1);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    nRST             = 1'b0;
    instr_valid      = 1'b0;
    vl               = 6'd0;
    sew              = SEW32;
    vm               = 1'b1;
    is_signed_mul    = 2'b10;
    high_low         = 1'b1;
    mul_widen_ena    = 1'b0;
    multiply_type    = 1'b1;
    multiply_pos_neg = 1'b0;
    rf_vs1           = 32'h0;
    rf_vs2           = 32'h0;
    rf_vs3           = 32'h0;
    maskVec          = 32'hFFFF_FFFF;
    wb_ready         = 1'b1;
    muEnable         = 1'b1;
    muSkipEidx       = -1;
    muLatency        = 2;
    clearCounters();

    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_instr_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst_rf_ren", 32'(rf_ren), 32'd0);
    checkOutput("rst_start_mu", 32'(start_mu), 32'd0);
    checkOutput("rst_decode_done", 32'(decode_done), 32'd0);
    checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rst_instr_done", 32'(instr_done), 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Unmasked vl=4, 3*5 per element.
    $display("[TB] basic vl=4 unmasked");
    clearCounters();
    applyStimulus(6'd4, 1'b1, 32'd3, 32'd5);
    waitDone("basic_done", 200);
    checkOutput("basic_wb_count", 32'(nWb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("basic_wb_eidx%0d", i), 32'(wbEidx[i]), 32'(i));
      checkOutput($sformatf("basic_wb_data%0d", i), wbData[i], 32'd15);
    end
    checkOutput("basic_start_count", 32'(nStart), 32'd4);
    checkOutput("basic_exc", 32'(lastExc), 32'd0);
    checkOutput("basic_start_dec_overlap", 32'(bothHigh), 32'd0);
    checkOutput("basic_dec_start_gap", 32'(gapViol), 32'd0);
    checkOutput("basic_mu_sew", {30'b0, mu_sew}, 32'd2);
    checkOutput("basic_mu_is_signed", {30'b0, mu_is_signed}, 32'd2);
    high_low = 1'b0;
    @(negedge CLK);
    checkOutput("basic_mu_high_low_latched", 32'(mu_high_low), 32'd1);
    checkOutput("basic_mu_type", 32'(mu_type), 32'd1);
    high_low = 1'b1;

    // Masked vl=4, mask 1010.
    $display("[TB] masked vl=4 mask=1010");
    clearCounters();
    maskVec = 32'b1010;
    applyStimulus(6'd4, 1'b0, 32'd3, 32'd5);
    waitDone("mask_done", 200);
    checkOutput("mask_wb_count", 32'(nWb), 32'd2);
    checkOutput("mask_wb_eidx0", 32'(wbEidx[0]), 32'd1);
    checkOutput("mask_wb_eidx1", 32'(wbEidx[1]), 32'd3);
    checkOutput("mask_start_count", 32'(nStart), 32'd2);
    checkOutput("mask_start_eidx0", 32'(startEidx[0]), 32'd1);
    checkOutput("mask_start_eidx1", 32'(startEidx[1]), 32'd3);
    checkOutput("mask_rf_reads", 32'(nRen), 32'd4);
    maskVec = 32'hFFFF_FFFF;

    // done_mu never arrives: watchdog abort.
    $display("[TB] timeout vl=2");
    clearCounters();
    muEnable = 1'b0;
    applyStimulus(6'd2, 1'b1, 32'd3, 32'd5);
    waitDone("tmo_done", 300);
    checkOutput("tmo_exc", 32'(lastExc), 32'd1);
    checkOutput("tmo_dec_latency", 32'(decCyc - startCyc), 32'd64);
    checkOutput("tmo_start_count", 32'(nStart), 32'd1);
    checkOutput("tmo_wb_count", 32'(nWbValid), 32'd0);
    muEnable = 1'b1;

    // Empty instruction.
    $display("[TB] vl=0");
    clearCounters();
    applyStimulus(6'd0, 1'b1, 32'd3, 32'd5);
    waitDone("vl0_done", 20);
    checkOutput("vl0_done_cycle", 32'(doneCyc), 32'(validCyc + 1));
    checkOutput("vl0_exc", 32'(lastExc), 32'd0);
    checkOutput("vl0_rf_reads", 32'(nRen), 32'd0);
    checkOutput("vl0_start_count", 32'(nStart), 32'd0);
    checkOutput("vl0_wb_valid", 32'(nWbValid), 32'd0);

    // Full-length instruction, index must stop at 31.
    $display("[TB] vl=VLMAX");
    clearCounters();
    muLatency = 1;
    applyStimulus(6'd32, 1'b1, 32'd7, 32'd6);
    waitDone("vlmax_done", 2000);
    checkOutput("vlmax_wb_count", 32'(nWb), 32'd32);
    checkOutput("vlmax_last_eidx", 32'(wbEidx[31]), 32'd31);
    checkOutput("vlmax_last_data", wbData[31], 32'd42);
    muLatency = 2;

    // Writeback stall on element 1.
    $display("[TB] writeback stall");
    clearCounters();
    applyStimulus(6'd4, 1'b1, 32'd3, 32'd5);
    n = 0;
    while (!(wb_valid === 1'b1 && wb_eidx === 5'd1) && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    wb_ready = 1'b0;
    checkOutput("stall_reached", 32'(n < 100), 32'd1);
    repeat (5) begin
      @(negedge CLK);
      checkOutput("stall_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("stall_wb_eidx", 32'(wb_eidx), 32'd1);
      checkOutput("stall_wb_data", wb_data, 32'd15);
    end
    checkOutput("stall_rf_reads", 32'(nRen), 32'd2);
    @(posedge CLK);
    #1;
    wb_ready = 1'b1;
    waitDone("stall_done", 200);
    checkOutput("stall_wb_count", 32'(nWb), 32'd4);
    checkOutput("stall_wb_eidx2", 32'(wbEidx[2]), 32'd2);

    // Reset while waiting on element 2.
    $display("[TB] reset during wait");
    clearCounters();
    muSkipEidx = 2;
    applyStimulus(6'd4, 1'b1, 32'd3, 32'd5);
    n = 0;
    while (!(start_mu === 1'b1 && rf_eidx === 5'd2) && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
    end
    checkOutput("midrst_reached", 32'(n < 200), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    checkOutput("midrst_instr_ready", 32'(instr_ready), 32'd1);
    checkOutput("midrst_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("midrst_rf_ren", 32'(rf_ren), 32'd0);
    checkOutput("midrst_start_mu", 32'(start_mu), 32'd0);
    checkOutput("midrst_decode_done", 32'(decode_done), 32'd0);
    checkOutput("midrst_vs1_data", vs1_data, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    nWbValid = 0;
    repeat (5) @(negedge CLK);
    checkOutput("midrst_no_done", 32'(nDone), 32'd0);
    checkOutput("midrst_wb_count", 32'(nWb), 32'd2);
    checkOutput("midrst_no_stray_wb", 32'(nWbValid), 32'd0);
    checkOutput("midrst_idle_ready", 32'(instr_ready), 32'd1);
    muSkipEidx = -1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
